// File: rtl/alu_mul_seq.sv
// Unsigned 8x8 shift-and-add multiply sequencer that borrows the CPU ALU for its
// add and shift steps and hands a 16-bit product back through a start/busy/done handshake.
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_t,
  output logic        alu_cy,
  output logic [4:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic [2:0]  alu_flag
);

  localparam logic [4:0]  OP_ZERO   = 5'b00000;
  localparam logic [4:0]  OP_ADD    = 5'b01000;
  localparam logic [4:0]  OP_SRL    = 5'b11000;
  localparam int unsigned CARRY_BIT = 0;

  typedef enum logic [2:0] {
    StIdle,
    StEval,
    StAdd,
    StShift,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  mq_q, mq_d;
  logic [7:0]  md_q, md_d;
  logic        c_q, c_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;

  // Only the carry flag matters; the other flag bits are deliberately ignored.
  logic unused_flag;
  assign unused_flag = ^alu_flag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      acc_q     <= 8'h00;
      mq_q      <= 8'h00;
      md_q      <= 8'h00;
      c_q       <= 1'b0;
      cnt_q     <= 4'd0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      md_q      <= md_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    md_d      = md_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          md_d    = mcand;
          mq_d    = mplier;
          acc_d   = 8'h00;
          c_d     = 1'b0;
          cnt_d   = 4'd8;
          state_d = StEval;
        end
      end
      StEval: begin
        c_d     = 1'b0;
        state_d = mq_q[0] ? StAdd : StShift;
      end
      StAdd: begin
        acc_d   = alu_result;
        c_d     = alu_flag[CARRY_BIT];
        state_d = StShift;
      end
      StShift: begin
        // {c, acc, mq} shifts right as one 17-bit partial product.
        acc_d = alu_result;
        mq_d  = {acc_q[0], mq_q[7:1]};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          product_d = {alu_result, acc_q[0], mq_q[7:1]};
          state_d   = StDone;
        end else begin
          state_d = StEval;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    alu_x  = acc_q;
    alu_t  = md_q;
    alu_cy = 1'b0;
    alu_op = OP_ZERO;
    unique case (state_q)
      StAdd: begin
        alu_op = OP_ADD;
      end
      StShift: begin
        alu_op = OP_SRL;
        alu_cy = c_q;
      end
      default: begin
        alu_op = OP_ZERO;
      end
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned 8×8 multiply sequencer that drives the 8-bit CPU ALU through its x/t/cy/alu_op inputs to form a 16-bit product by shift-and-add. It sits beside the ALU and is the only master of the ALU operand and opcode lines while it is instantiated. Results and flags are taken back from alu_result and alu_flag. It exposes a start/busy/done handshake to the instruction control unit.

## Interface

- OP_ZERO, 5'b00000, ALU opcode driven when no arithmetic is needed
- OP_ADD, 5'b01000, ALU add opcode: x + t + cy
- OP_SRL, 5'b11000, ALU shift-right-logical opcode: result = {cy, x[7:1]}
- CARRY_BIT, 0, index of the carry-out bit within alu_flag

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a multiply; accepted only in IDLE
- mcand  in  8  multiplicand, sampled on the accepting edge
- mplier  in  8  multiplier, sampled on the accepting edge
- busy  out  1  high from the cycle after acceptance through DONE
- done  out  1  one-cycle pulse; product valid from this cycle on
- product  out  16  registered result; holds until the next done
- alu_x  out  8  ALU x operand (accumulator)
- alu_t  out  8  ALU t operand (multiplicand register)
- alu_cy  out  1  ALU carry-in
- alu_op  out  5  ALU opcode
- alu_result  in  8  ALU result
- alu_flag  in  3  ALU flags; only alu_flag[CARRY_BIT] is used

## Operation

- Internal registers: acc[7:0], mq[7:0], md[7:0], c (1 b), cnt[3:0], state.
- States: IDLE, EVAL, ADD, SHIFT, DONE.
- IDLE: when start = 1, load md ← mcand, mq ← mplier, acc ← 0, c ← 0, cnt ← 8, then go to EVAL. Otherwise stay in IDLE.
- EVAL: c ← 0. Go to ADD if mq[0] = 1, else go to SHIFT.
- ADD: drive alu_op = OP_ADD, alu_x = acc, alu_t = md, alu_cy = 0. Latch acc ← alu_result and c ← alu_flag[CARRY_BIT]. Then go to SHIFT.
- SHIFT: drive alu_op = OP_SRL, alu_x = acc, alu_cy = c.
  - Latch acc ← alu_result, mq ← {acc[0], mq[7:1]}, cnt ← cnt − 1.
  - If cnt = 1, go to DONE and load product ← {alu_result, acc[0], mq[7:1]}. Otherwise go to EVAL.
- DONE: assert done. Return to IDLE.
- In IDLE, EVAL and DONE, drive alu_op = OP_ZERO, alu_x = acc, alu_t = md, alu_cy = 0.
- ALU outputs are a combinational decode of the registered state and registers.
- Width rule: the ADD carry is held in c and shifted into acc[7] on the following SHIFT. This makes {c, acc, mq} a 17-bit partial product, so no overflow is possible and product = mcand × mplier exactly.
- start is ignored in every state other than IDLE, including DONE. It is neither queued nor allowed to abort the operation in progress.
- Reset (any time, including mid-operation) forces the following immediately:
  - state = IDLE
  - busy = 0, done = 0, product = 0
  - acc = mq = md = 0, c = 0, cnt = 0
  - alu_op = OP_ZERO, alu_x = alu_t = 0, alu_cy = 0

## Timing

- Acceptance edge E: start = 1 sampled in IDLE. busy = 1 from E+1.
- Each multiplier bit takes EVAL + SHIFT (2 cycles), plus 1 ADD cycle if the bit is 1.
- done is high in exactly one cycle, at edge E + 17 + popcount(mplier):
  - minimum latency 17 (mplier = 0)
  - maximum latency 25 (mplier = 0xFF)
- product updates on the same edge that enters DONE.
- busy is still 1 during DONE and falls on the following edge.
- The earliest a new start can be accepted is the first IDLE cycle after DONE, i.e. one cycle after done.
- The ALU is treated as purely combinational within one cycle. alu_result and alu_flag are sampled on the edge that ends ADD or SHIFT.

## Test plan

- mcand = 0xAA, mplier = 0x55 → product = 0x3872, done at E+21. Trace on alu_op:
  - ADD appears 4 times
  - SRL appears 8 times
  - 00000 appears in every EVAL cycle
- mcand = 0xFF, mplier = 0xFF → product = 0xFE01, done at E+25. alu_cy = 1 on the SHIFTs following ADDs that carry out.
- mcand = 0x37, mplier = 0x00 → product = 0x0000, done at E+17, no ADD cycles. Then mcand = 0x00, mplier = 0x0F → product = 0x0000, done at E+21.
- Start held high continuously with mcand = 0x0F, mplier = 0x0F:
  - first product = 0x00E1 at E+21
  - start is ignored while busy and in DONE
  - the next acceptance occurs at the first IDLE cycle
  - product holds 0x00E1 until the second done
- Assert reset_n = 0 at E+9 during a 0xFF × 0xFF operation → immediately:
  - busy = 0, product = 0x0000, alu_op = 00000
  - no done pulse
  - a subsequent 0x02 × 0x03 gives 0x0006 at E'+19
- Random 200 operand pairs → product equals a × b, and done latency equals 17 + popcount(mplier).
